// File: rtl/match_ctl.sv
// match_ctl: Pong match flow controller.
// Owns the match state machine (idle/serve/play/pause/over), the two score
// counters, the frame-timed serve delay and the registered winner flag.
// Every output comes straight from a register; no input reaches an output
// combinationally.
module match_ctl #(
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 3,
   parameter int SERVE_DELAY = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               button,
   input  logic               pause,
   input  logic               serve_req,
   input  logic               goal_p1,
   input  logic               goal_p2,
   output logic [2:0]         state,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic [1:0]         winner,
   output logic               ball_enable,
   output logic               ball_reset,
   output logic               serve_dir
);

   localparam int CNT_W = $clog2(SERVE_DELAY + 1);

   localparam logic [CNT_W-1:0]   DELAY_V = CNT_W'(SERVE_DELAY);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ZERO = '0;
   localparam logic [SCORE_W-1:0] WIN_V   = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] SC_ONE  = SCORE_W'(1);
   localparam logic [SCORE_W-1:0] SC_ZERO = '0;
   localparam logic [SCORE_W-1:0] SC_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t             cur;
   state_t             nxt;
   logic               button_q;
   logic               pause_q;
   logic               armed;
   logic               btn_rise;
   logic               pse_rise;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [SCORE_W-1:0] s1_nxt;
   logic [SCORE_W-1:0] s2_nxt;
   logic [1:0]         winner_nxt;
   logic               dir_nxt;

   // Saturating score increment: holds at all-ones instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      if (v == SC_MAX) begin
         return v;
      end else begin
         return v + SC_ONE;
      end
   endfunction

   // Input history for rising-edge detection. 'armed' masks the first clock
   // after reset so a button held through reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         button_q <= 1'b0;
         pause_q  <= 1'b0;
         armed    <= 1'b0;
      end else begin
         button_q <= button;
         pause_q  <= pause;
         armed    <= 1'b1;
      end
   end

   assign btn_rise = button & ~button_q & armed;
   assign pse_rise = pause & ~pause_q;

   // Next-state, counter and score decisions for the match flow.
   always_comb begin
      nxt        = cur;
      cnt_nxt    = cnt;
      s1_nxt     = score_p1;
      s2_nxt     = score_p2;
      winner_nxt = winner;
      dir_nxt    = serve_dir;
      case (cur)
         S_IDLE: begin
            s1_nxt     = SC_ZERO;
            s2_nxt     = SC_ZERO;
            winner_nxt = 2'b00;
            if (btn_rise) begin
               nxt     = S_SERVE;
               cnt_nxt = DELAY_V;
            end else begin
               nxt = S_IDLE;
            end
         end
         S_SERVE: begin
            if (cnt == CNT_ZERO) begin
               if (serve_req) begin
                  nxt = S_PLAY;
               end else begin
                  nxt = S_SERVE;
               end
            end else if (frame_tick) begin
               cnt_nxt = cnt - CNT_ONE;
            end else begin
               cnt_nxt = cnt;
            end
         end
         S_PLAY: begin
            if (goal_p1 && goal_p2) begin
               // A let: replay the serve, nobody scores.
               nxt     = S_SERVE;
               cnt_nxt = DELAY_V;
            end else if (goal_p1) begin
               s1_nxt = sat_inc(score_p1);
               if (s1_nxt == WIN_V) begin
                  nxt        = S_OVER;
                  winner_nxt = 2'b01;
               end else begin
                  nxt     = S_SERVE;
                  cnt_nxt = DELAY_V;
                  dir_nxt = 1'b1;
               end
            end else if (goal_p2) begin
               s2_nxt = sat_inc(score_p2);
               if (s2_nxt == WIN_V) begin
                  nxt        = S_OVER;
                  winner_nxt = 2'b10;
               end else begin
                  nxt     = S_SERVE;
                  cnt_nxt = DELAY_V;
                  dir_nxt = 1'b0;
               end
            end else if (pse_rise) begin
               nxt = S_PAUSE;
            end else begin
               nxt = S_PLAY;
            end
         end
         S_PAUSE: begin
            if (btn_rise) begin
               nxt        = S_IDLE;
               s1_nxt     = SC_ZERO;
               s2_nxt     = SC_ZERO;
               winner_nxt = 2'b00;
            end else if (pse_rise) begin
               nxt = S_PLAY;
            end else begin
               nxt = S_PAUSE;
            end
         end
         S_OVER: begin
            if (btn_rise) begin
               nxt        = S_IDLE;
               s1_nxt     = SC_ZERO;
               s2_nxt     = SC_ZERO;
               winner_nxt = 2'b00;
            end else begin
               nxt = S_OVER;
            end
         end
         default: begin
            nxt        = S_IDLE;
            cnt_nxt    = CNT_ZERO;
            s1_nxt     = SC_ZERO;
            s2_nxt     = SC_ZERO;
            winner_nxt = 2'b00;
            dir_nxt    = 1'b0;
         end
      endcase
   end

   // State, counters and flag outputs; flags decode the next state so they
   // change on the same edge as the state itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur         <= S_IDLE;
         cnt         <= CNT_ZERO;
         score_p1    <= SC_ZERO;
         score_p2    <= SC_ZERO;
         winner      <= 2'b00;
         serve_dir   <= 1'b0;
         ball_enable <= 1'b0;
         ball_reset  <= 1'b1;
      end else begin
         cur         <= nxt;
         cnt         <= cnt_nxt;
         score_p1    <= s1_nxt;
         score_p2    <= s2_nxt;
         winner      <= winner_nxt;
         serve_dir   <= dir_nxt;
         ball_enable <= (nxt == S_PLAY);
         ball_reset  <= (nxt == S_IDLE) || (nxt == S_SERVE);
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_match_ctl.sv
// Directed testbench for match_ctl with default parameters
// (SCORE_W=4, WIN_SCORE=3, SERVE_DELAY=60).
module tb_match_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_tick;
   logic       button;
   logic       pause;
   logic       serve_req;
   logic       goal_p1;
   logic       goal_p2;
   logic [2:0] state;
   logic [3:0] score_p1;
   logic [3:0] score_p2;
   logic [1:0] winner;
   logic       ball_enable;
   logic       ball_reset;
   logic       serve_dir;

   int checks = 0;
   int errors = 0;

   match_ctl #(.SCORE_W(4), .WIN_SCORE(3), .SERVE_DELAY(60)) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .button     (button),
      .pause      (pause),
      .serve_req  (serve_req),
      .goal_p1    (goal_p1),
      .goal_p2    (goal_p2),
      .state      (state),
      .score_p1   (score_p1),
      .score_p2   (score_p2),
      .winner     (winner),
      .ball_enable(ball_enable),
      .ball_reset (ball_reset),
      .serve_dir  (serve_dir)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_p1"}, 32'(score_p1), 32'd0);
      chk({tag, "_p2"}, 32'(score_p2), 32'd0);
      chk({tag, "_win"}, 32'(winner), 32'd0);
      chk({tag, "_ben"}, 32'(ball_enable), 32'd0);
      chk({tag, "_brst"}, 32'(ball_reset), 32'd1);
      chk({tag, "_dir"}, 32'(serve_dir), 32'd0);
   endtask

   // 60 frame ticks (one every other clock); state must stay SERVE throughout.
   // hold=1 keeps serve_req high the whole time; otherwise an early serve_req
   // is pulsed mid-delay and must be ignored, then a real one is given.
   task automatic serve_seq(input bit hold);
      serve_req = hold;
      for (int i = 1; i <= 60; i++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         chk("serve_wait", 32'(state), 32'd1);
         if (i < 60) begin
            if (!hold && i == 30) serve_req = 1'b1;
            tick();
            serve_req = hold;
            chk("serve_gap", 32'(state), 32'd1);
         end
      end
      serve_req = 1'b1;
      tick();
      serve_req = 1'b0;
      chk("serve_play", 32'(state), 32'd2);
      chk("serve_ben", 32'(ball_enable), 32'd1);
      chk("serve_brst", 32'(ball_reset), 32'd0);
   endtask

   initial begin
      rst = 1'b1; frame_tick = 1'b0; button = 1'b0; pause = 1'b0;
      serve_req = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
      tick(); tick();
      chk_reset_vals("rst");
      rst = 1'b0;
      tick(); tick();
      chk("idle_hold", 32'(state), 32'd0);

      // Start: button held 3 clocks, one rise only.
      button = 1'b1;
      tick();
      chk("start_state", 32'(state), 32'd1);
      chk("start_brst", 32'(ball_reset), 32'd1);
      chk("start_ben", 32'(ball_enable), 32'd0);
      tick(); tick();
      button = 1'b0;
      tick();
      chk("start_stay", 32'(state), 32'd1);
      serve_seq(1'b0);

      // Player 1 wins 3-0.
      goal_p1 = 1'b1; tick(); goal_p1 = 1'b0;
      chk("g1_score", 32'(score_p1), 32'd1);
      chk("g1_state", 32'(state), 32'd1);
      chk("g1_dir", 32'(serve_dir), 32'd1);
      serve_seq(1'b0);
      goal_p1 = 1'b1; tick(); goal_p1 = 1'b0;
      chk("g2_score", 32'(score_p1), 32'd2);
      chk("g2_state", 32'(state), 32'd1);
      chk("g2_dir", 32'(serve_dir), 32'd1);
      serve_seq(1'b0);
      goal_p1 = 1'b1; tick(); goal_p1 = 1'b0;
      chk("g3_score", 32'(score_p1), 32'd3);
      chk("g3_state", 32'(state), 32'd4);
      chk("g3_winner", 32'(winner), 32'd1);
      chk("g3_ben", 32'(ball_enable), 32'd0);
      chk("g3_brst", 32'(ball_reset), 32'd0);
      goal_p2 = 1'b1; tick(); goal_p2 = 1'b0;
      chk("over_p2_hold", 32'(score_p2), 32'd0);
      chk("over_state", 32'(state), 32'd4);
      button = 1'b1; tick(); button = 1'b0;
      chk("restart_state", 32'(state), 32'd0);
      chk("restart_p1", 32'(score_p1), 32'd0);
      chk("restart_win", 32'(winner), 32'd0);
      tick();

      // New match; one goal then a let.
      button = 1'b1; tick(); button = 1'b0;
      chk("m2_state", 32'(state), 32'd1);
      serve_seq(1'b0);
      goal_p1 = 1'b1; tick(); goal_p1 = 1'b0;
      chk("m2_g1", 32'(score_p1), 32'd1);
      serve_seq(1'b0);
      goal_p1 = 1'b1; goal_p2 = 1'b1; tick(); goal_p1 = 1'b0; goal_p2 = 1'b0;
      chk("let_state", 32'(state), 32'd1);
      chk("let_p1", 32'(score_p1), 32'd1);
      chk("let_p2", 32'(score_p2), 32'd0);
      chk("let_dir", 32'(serve_dir), 32'd1);
      serve_seq(1'b0);

      // Pause / resume; goal during pause ignored; pause+goal -> goal wins.
      pause = 1'b1; tick();
      chk("pause_state", 32'(state), 32'd3);
      chk("pause_ben", 32'(ball_enable), 32'd0);
      goal_p2 = 1'b1; frame_tick = 1'b1; tick(); goal_p2 = 1'b0; frame_tick = 1'b0;
      chk("pause_goal_ign", 32'(score_p2), 32'd0);
      chk("pause_stay", 32'(state), 32'd3);
      pause = 1'b0; tick();
      pause = 1'b1; tick();
      chk("resume_state", 32'(state), 32'd2);
      chk("resume_ben", 32'(ball_enable), 32'd1);
      pause = 1'b0; tick();
      pause = 1'b1; goal_p2 = 1'b1; tick(); pause = 1'b0; goal_p2 = 1'b0;
      chk("pg_score", 32'(score_p2), 32'd1);
      chk("pg_state", 32'(state), 32'd1);
      chk("pg_dir", 32'(serve_dir), 32'd0);
      tick();

      // serve_req held through the whole delay.
      serve_seq(1'b1);

      // Button rise in PLAY does nothing.
      button = 1'b1; tick(); button = 1'b0;
      chk("play_btn_ign", 32'(state), 32'd2);
      tick();

      // Reach score_p1=2 mid-PLAY, then async reset with button held.
      goal_p1 = 1'b1; tick(); goal_p1 = 1'b0;
      chk("pre_rst_p1", 32'(score_p1), 32'd2);
      serve_seq(1'b0);
      button = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("held_no_start", 32'(state), 32'd0);
      button = 1'b0; tick();
      chk("release_idle", 32'(state), 32'd0);
      button = 1'b1; tick(); button = 1'b0;
      chk("repress_start", 32'(state), 32'd1);
      chk("repress_p1", 32'(score_p1), 32'd0);

      // Abort from PAUSE back to IDLE.
      serve_seq(1'b0);
      goal_p2 = 1'b1; tick(); goal_p2 = 1'b0;
      serve_seq(1'b0);
      pause = 1'b1; tick(); pause = 1'b0;
      chk("abort_pause", 32'(state), 32'd3);
      button = 1'b1; tick(); button = 1'b0;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_p2", 32'(score_p2), 32'd0);
      chk("abort_brst", 32'(ball_reset), 32'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
